// File: rtl/mpc_out_pkg.sv
// Shared types and width helpers for the multi-port cache output controller.
package mpc_out_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_LEN,
        WAIT_LEN,
        REQ_BLK,
        WAIT_BLK,
        WAIT_DONE
    } state_t;

    function automatic int blk_shift(input int blk_bytes);
        return $clog2(blk_bytes);
    endfunction

    function automatic int word_shift(input int word_bytes);
        return $clog2(word_bytes);
    endfunction

    function automatic int times_w(input int blk_bytes, input int word_bytes);
        return $clog2(blk_bytes / word_bytes) + 1;
    endfunction

endpackage

// File: rtl/port_req_fifo.sv
// Pending-grant FIFO with registered full/empty flags.
module port_req_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_n;
    logic             do_push;
    logic             do_pop;

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_data  = mem[rd_ptr];

    always_comb begin
        count_n = count;
        unique case ({do_push, do_pop})
            2'b10:   count_n = count + CW'(1);
            2'b01:   count_n = count - CW'(1);
            default: count_n = count;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_n;
            o_full  <= (count_n == CW'(DEPTH));
            o_empty <= (count_n == '0);
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_data;
    end

endmodule

// File: rtl/pkt_read_ctrl.sv
// Per-port output controller: serves queued grants one packet at a time,
// walking the packet's blocks and handing each address to the read engine.
module pkt_read_ctrl
    import mpc_out_pkg::*;
#(
    parameter int PORTNUM        = 16,
    parameter int BLK_ADDR_WIDTH = 10,
    parameter int LEN_WIDTH      = 10,
    parameter int BLK_BYTES      = 32,
    parameter int WORD_BYTES     = 4,
    parameter int REQ_DEPTH      = 4
) (
    input  logic                                      i_clk,
    input  logic                                      i_rst,
    input  logic [$clog2(PORTNUM)-1:0]                i_port,
    input  logic                                      i_port_vld,
    output logic                                      o_port_rdy,
    output logic [$clog2(PORTNUM)-1:0]                o_port,
    output logic                                      o_port_vld,
    input  logic [LEN_WIDTH-1:0]                      i_len,
    input  logic                                      i_len_vld,
    output logic                                      o_blk_req,
    input  logic [BLK_ADDR_WIDTH-1:0]                 i_blk_addr,
    input  logic                                      i_blk_addr_vld,
    output logic [BLK_ADDR_WIDTH-1:0]                 o_blk_addr,
    output logic                                      o_blk_addr_vld,
    output logic                                      o_last_blk_vld,
    output logic [times_w(BLK_BYTES, WORD_BYTES)-1:0] o_last_r_times,
    input  logic                                      i_r_done,
    output logic                                      o_pkt_done,
    output logic                                      o_len_err,
    output logic                                      o_busy
);

    localparam int PW  = $clog2(PORTNUM);
    localparam int BS  = blk_shift(BLK_BYTES);
    localparam int WS  = word_shift(WORD_BYTES);
    localparam int TW  = times_w(BLK_BYTES, WORD_BYTES);
    localparam int CW  = LEN_WIDTH - BS + 1;
    localparam int LBW = BS + 1;
    localparam int LW1 = LEN_WIDTH + 1;

    state_t state;
    state_t state_n;

    logic [PW-1:0] fifo_port;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

    logic [CW-1:0] blk_cnt;
    logic [CW-1:0] blk_idx;
    logic          is_last;

    logic [LEN_WIDTH:0] len_up;
    logic [CW-1:0]      cnt_calc;
    logic [LBW-1:0]     last_bytes;
    logic [LBW-1:0]     lb_up;
    logic [TW-1:0]      times_calc;

    logic [PW-1:0]             port_n;
    logic [CW-1:0]             cnt_n;
    logic [CW-1:0]             idx_n;
    logic [TW-1:0]             times_n;
    logic [BLK_ADDR_WIDTH-1:0] addr_n;
    logic port_vld_n;
    logic blk_req_n;
    logic addr_vld_n;
    logic last_n;
    logic done_n;
    logic err_n;

    port_req_fifo #(
        .WIDTH (PW),
        .DEPTH (REQ_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (i_port_vld),
        .i_data  (i_port),
        .i_pop   (pop),
        .o_data  (fifo_port),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign o_port_rdy = ~fifo_full;

    // Ceiling divisions by shift; a zero remainder means a full last block.
    assign len_up     = {1'b0, i_len} + LW1'(BLK_BYTES - 1);
    assign cnt_calc   = len_up[LEN_WIDTH:BS];
    assign last_bytes = (i_len[BS-1:0] == '0) ? LBW'(BLK_BYTES)
                                              : {1'b0, i_len[BS-1:0]};
    assign lb_up      = last_bytes + LBW'(WORD_BYTES - 1);
    assign times_calc = lb_up[BS:WS];

    assign is_last = (blk_idx == blk_cnt - CW'(1));

    always_comb begin
        state_n    = state;
        port_n     = o_port;
        cnt_n      = blk_cnt;
        idx_n      = blk_idx;
        times_n    = o_last_r_times;
        addr_n     = o_blk_addr;
        pop        = 1'b0;
        port_vld_n = 1'b0;
        blk_req_n  = 1'b0;
        addr_vld_n = 1'b0;
        last_n     = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    port_n     = fifo_port;
                    port_vld_n = 1'b1;
                    state_n    = REQ_LEN;
                end
            end
            REQ_LEN: state_n = WAIT_LEN;
            WAIT_LEN: begin
                if (i_len_vld) begin
                    if (i_len == '0) begin
                        err_n   = 1'b1;
                        state_n = IDLE;
                    end else begin
                        cnt_n   = cnt_calc;
                        times_n = times_calc;
                        idx_n   = '0;
                        state_n = REQ_BLK;
                    end
                end
            end
            REQ_BLK: begin
                blk_req_n = 1'b1;
                state_n   = WAIT_BLK;
            end
            WAIT_BLK: begin
                if (i_blk_addr_vld) begin
                    addr_n     = i_blk_addr;
                    addr_vld_n = 1'b1;
                    last_n     = is_last;
                    state_n    = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_r_done) begin
                    if (is_last) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        idx_n   = blk_idx + CW'(1);
                        state_n = REQ_BLK;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            o_port         <= '0;
            blk_cnt        <= '0;
            blk_idx        <= '0;
            o_last_r_times <= '0;
            o_blk_addr     <= '0;
            o_port_vld     <= 1'b0;
            o_blk_req      <= 1'b0;
            o_blk_addr_vld <= 1'b0;
            o_last_blk_vld <= 1'b0;
            o_pkt_done     <= 1'b0;
            o_len_err      <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            state          <= state_n;
            o_port         <= port_n;
            blk_cnt        <= cnt_n;
            blk_idx        <= idx_n;
            o_last_r_times <= times_n;
            o_blk_addr     <= addr_n;
            o_port_vld     <= port_vld_n;
            o_blk_req      <= blk_req_n;
            o_blk_addr_vld <= addr_vld_n;
            o_last_blk_vld <= last_n;
            o_pkt_done     <= done_n;
            o_len_err      <= err_n;
            o_busy         <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_pkt_read_ctrl.sv
// Scoreboard bench for pkt_read_ctrl with reactive queue-manager/read-engine models.
module tb_pkt_read_ctrl;

    localparam int LW  = 10;
    localparam int BAW = 10;
    localparam int TW  = 4;

    logic           i_clk = 1'b0;
    logic           i_rst = 1'b1;
    logic [3:0]     i_port = '0;
    logic           i_port_vld = 1'b0;
    logic           o_port_rdy;
    logic [3:0]     o_port;
    logic           o_port_vld;
    logic [LW-1:0]  i_len = '0;
    logic           i_len_vld = 1'b0;
    logic           o_blk_req;
    logic [BAW-1:0] i_blk_addr;
    logic           i_blk_addr_vld;
    logic [BAW-1:0] o_blk_addr;
    logic           o_blk_addr_vld;
    logic           o_last_blk_vld;
    logic [TW-1:0]  o_last_r_times;
    logic           i_r_done;
    logic           o_pkt_done;
    logic           o_len_err;
    logic           o_busy;

    logic [BAW-1:0] addr_r = '0;
    logic addr_vld_r = 1'b0;
    logic addr_vld_j = 1'b0;
    logic done_r = 1'b0;
    logic done_j = 1'b0;

    assign i_blk_addr_vld = addr_vld_r | addr_vld_j;
    assign i_blk_addr     = addr_vld_r ? addr_r : '1;
    assign i_r_done       = done_r | done_j;

    always #5 i_clk = ~i_clk;

    pkt_read_ctrl dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_port         (i_port),
        .i_port_vld     (i_port_vld),
        .o_port_rdy     (o_port_rdy),
        .o_port         (o_port),
        .o_port_vld     (o_port_vld),
        .i_len          (i_len),
        .i_len_vld      (i_len_vld),
        .o_blk_req      (o_blk_req),
        .i_blk_addr     (i_blk_addr),
        .i_blk_addr_vld (i_blk_addr_vld),
        .o_blk_addr     (o_blk_addr),
        .o_blk_addr_vld (o_blk_addr_vld),
        .o_last_blk_vld (o_last_blk_vld),
        .o_last_r_times (o_last_r_times),
        .i_r_done       (i_r_done),
        .o_pkt_done     (o_pkt_done),
        .o_len_err      (o_len_err),
        .o_busy         (o_busy)
    );

    typedef enum int {EV_PORT, EV_ERR, EV_REQ, EV_ADDR, EV_DONE} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       port;
        int       addr;
        bit       last;
        int       times;
    } ev_t;

    ev_t exp_q[$];
    int  len_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    bit hold_len  = 1'b0;
    bit junk_en   = 1'b0;
    int stall_blk = -1;
    int junk_cnt  = 0;
    bit pend_len  = 1'b0;
    int cur_port  = 0;
    int blk_i     = 0;

    function automatic ev_t mk(ev_kind_e k, int p, int a, bit l, int t);
        ev_t e;
        e.kind  = k;
        e.port  = p;
        e.addr  = a;
        e.last  = l;
        e.times = t;
        return e;
    endfunction

    // Reference model: ceil division by plain integer arithmetic.
    task automatic push_pkt(input int p, input int len, input int lim);
        int nb, lb, t;
        exp_q.push_back(mk(EV_PORT, p, 0, 0, 0));
        len_q.push_back(len);
        if (len == 0) begin
            exp_q.push_back(mk(EV_ERR, p, 0, 0, 0));
            return;
        end
        nb = (len + 31) / 32;
        lb = len - (nb - 1) * 32;
        t  = (lb + 3) / 4;
        for (int i = 0; i < nb && i < lim; i++) begin
            exp_q.push_back(mk(EV_REQ, p, 0, 0, 0));
            exp_q.push_back(mk(EV_ADDR, p, p * 32 + i, (i == nb - 1), t));
        end
        if (lim >= nb) exp_q.push_back(mk(EV_DONE, p, 0, 0, 0));
    endtask

    task automatic see(input ev_kind_e k);
        ev_t e;
        bit  bad;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_%s: port=%0d addr=%0d, expected no event",
                     k.name(), o_port, o_blk_addr);
            return;
        end
        e   = exp_q.pop_front();
        bad = (e.kind != k);
        if (!bad && k == EV_PORT) bad = (int'(o_port) != e.port);
        if (!bad && k == EV_ADDR)
            bad = (int'(o_blk_addr) != e.addr) || (o_last_blk_vld != e.last) ||
                  (int'(o_port) != e.port) ||
                  (e.last && int'(o_last_r_times) != e.times);
        if (bad) begin
            n_errors++;
            $display("FAIL %s: got port=%0d addr=%0d last=%0b times=%0d, expected %s port=%0d addr=%0d last=%0b times=%0d",
                     k.name(), o_port, o_blk_addr, o_last_blk_vld, o_last_r_times,
                     e.kind.name(), e.port, e.addr, e.last, e.times);
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_port_rdy"}, o_port_rdy, 1);
        chk({tag, "_port"}, o_port, 0);
        chk({tag, "_port_vld"}, o_port_vld, 0);
        chk({tag, "_blk_req"}, o_blk_req, 0);
        chk({tag, "_blk_addr"}, o_blk_addr, 0);
        chk({tag, "_blk_addr_vld"}, o_blk_addr_vld, 0);
        chk({tag, "_last_blk_vld"}, o_last_blk_vld, 0);
        chk({tag, "_last_r_times"}, o_last_r_times, 0);
        chk({tag, "_pkt_done"}, o_pkt_done, 0);
        chk({tag, "_len_err"}, o_len_err, 0);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    // lim < 0: grant is offered but no response is expected for it.
    task automatic offer(input int p, input int len, input int lim, output bit acc);
        acc        = o_port_rdy;
        i_port     = 4'(p);
        i_port_vld = 1'b1;
        if (acc && lim >= 0) push_pkt(p, len, lim);
        @(negedge i_clk);
        i_port_vld = 1'b0;
    endtask

    task automatic wait_q(input int limit, input bit need_idle);
        int n = 0;
        while ((exp_q.size() != 0 || (need_idle && o_busy)) && n < limit) begin
            @(negedge i_clk);
            n++;
        end
        n_checks++;
        if (n >= limit) begin
            n_errors++;
            $display("FAIL drain: %0d events still pending after %0d cycles",
                     exp_q.size(), limit);
            exp_q.delete();
        end
    endtask

    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_port_vld)     see(EV_PORT);
            if (o_len_err)      see(EV_ERR);
            if (o_blk_req)      see(EV_REQ);
            if (o_blk_addr_vld) see(EV_ADDR);
            if (o_pkt_done)     see(EV_DONE);
        end
    end

    // Queue manager and read engine models, plus stray-pulse injection.
    always @(negedge i_clk) begin
        i_len_vld  = 1'b0;
        addr_vld_r = 1'b0;
        done_r     = 1'b0;
        addr_vld_j = 1'b0;
        done_j     = 1'b0;
        if (i_rst) begin
            pend_len = 1'b0;
            blk_i    = 0;
            junk_cnt = 0;
        end else begin
            if (pend_len && !hold_len) begin
                if (len_q.size() > 0) i_len = LW'(len_q.pop_front());
                else i_len = '0;
                i_len_vld = 1'b1;
                pend_len  = 1'b0;
            end
            if (o_port_vld) begin
                pend_len = 1'b1;
                cur_port = int'(o_port);
                blk_i    = 0;
                if (junk_en) junk_cnt = 2;
            end
            if (o_blk_req) begin
                addr_r     = BAW'(cur_port * 32 + blk_i);
                addr_vld_r = 1'b1;
                if (junk_en) done_j = 1'b1;
            end
            if (o_blk_addr_vld) begin
                if (blk_i != stall_blk) done_r = 1'b1;
                blk_i++;
            end
            if (junk_cnt > 0) begin
                addr_vld_j = 1'b1;
                done_j     = 1'b1;
                junk_cnt--;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        repeat (3) @(negedge i_clk);
        check_reset_outs("rst");
        i_rst = 1'b0;
        @(negedge i_clk);
        check_reset_outs("post_rst");

        // 123 bytes: 4 blocks, last has 27 bytes -> 7 beats
        offer(4, 123, 1000, acc);
        @(negedge i_clk);
        chk("grant_latency_port_vld", o_port_vld, 1);
        chk("grant_latency_port", o_port, 4);
        wait_q(300, 1);

        // back-to-back grants exercise simultaneous push and pop
        offer(2, 64, 1000, acc);
        offer(3, 1, 1000, acc);
        wait_q(300, 1);

        offer(5, 0, 1000, acc);
        offer(6, 40, 1000, acc);
        wait_q(300, 1);

        // stall the length response so later grants pile up
        hold_len = 1'b1;
        offer(1, 33, 1000, acc);
        chk("acc_1", acc, 1);
        offer(2, 32, 1000, acc);
        chk("acc_2", acc, 1);
        offer(3, 96, 1000, acc);
        chk("acc_3", acc, 1);
        offer(4, 5, 1000, acc);
        chk("acc_4", acc, 1);
        offer(5, 31, 1000, acc);
        chk("acc_5", acc, 1);
        offer(6, 20, -1, acc);
        chk("full_reject", acc, 0);
        chk("busy_while_held", o_busy, 1);
        hold_len = 1'b0;
        wait_q(1000, 1);
        chk("rdy_after_drain", o_port_rdy, 1);

        // stray strobes while idle and in the wrong states
        junk_cnt = 3;
        repeat (4) @(negedge i_clk);
        chk("junk_idle_busy", o_busy, 0);
        junk_en = 1'b1;
        offer(8, 70, 1000, acc);
        wait_q(300, 1);
        junk_en = 1'b0;

        // abort during block 2 with another grant still queued
        stall_blk = 1;
        offer(7, 100, 2, acc);
        wait_q(300, 0);
        offer(9, 50, -1, acc);
        repeat (3) @(negedge i_clk);
        chk("busy_before_abort", o_busy, 1);
        i_rst = 1'b1;
        @(negedge i_clk);
        check_reset_outs("abort");
        @(negedge i_clk);
        i_rst     = 1'b0;
        stall_blk = -1;
        len_q.delete();
        repeat (10) @(negedge i_clk);
        chk("abort_idle", o_busy, 0);

        // maximum length: 32 blocks, last 31 bytes -> 8 beats
        offer(10, 1023, 1000, acc);
        wait_q(1000, 1);
        offer(11, 32, 1000, acc);
        wait_q(300, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
